// File: rtl/alu_muldiv_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// The requester drives start/op/operands through the master modport;
// alu_muldiv consumes them through the slave modport.
interface alu_muldiv_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned OP_SEL = 3
);
  logic              start;
  logic [OP_SEL-1:0] op;
  logic [WIDTH-1:0]  bus_a;
  logic [WIDTH-1:0]  bus_b;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              res_zero;
  logic              res_neg;

  modport master (
    output start, op, bus_a, bus_b,
    input  busy, done, result, res_zero, res_neg
  );

  modport slave (
    input  start, op, bus_a, bus_b,
    output busy, done, result, res_zero, res_neg
  );
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M multiply/divide unit (funct3 op encoding).
// Multiplies use radix-2 shift-add, divides use restoring division, one bit per cycle,
// both on magnitudes with a final sign fix-up. Divide-by-zero and signed overflow bypass
// the iteration and complete one cycle after start.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use one combinational product
// computed in a single CALC cycle; the divide path is unchanged.
module alu_muldiv #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned OP_SEL = 3
) (
  input logic         clk,
  input logic         rst_n,
  alu_muldiv_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q;
  logic [OP_SEL-1:0]   op_q;
  logic [WIDTH-1:0]    opa_q;     // |rs1|: multiplicand, or dividend seed
  logic [WIDTH-1:0]    opb_q;     // |rs2|: multiplier seed, or divisor
  logic                neg_q;     // negate the final result
  logic [2*WIDTH-1:0]  acc_q;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [CntW-1:0]     cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [WIDTH-1:0]    result_q;
  logic                res_zero_q;
  logic                res_neg_q;

  // Start-side decode: operand signedness, magnitudes, result sign, bypass cases
  logic              is_div, a_signed, b_signed, sign_a, sign_b;
  logic              div_zero, div_ovf, special, neg_start;
  logic [WIDTH-1:0]  mag_a, mag_b, spec_res;

  always_comb begin
    is_div    = bus.op[2];
    a_signed  = is_div ? !bus.op[0] : (bus.op[1:0] != 2'b11);
    b_signed  = is_div ? !bus.op[0] : !bus.op[1];
    sign_a    = a_signed & bus.bus_a[WIDTH-1];
    sign_b    = b_signed & bus.bus_b[WIDTH-1];
    mag_a     = sign_a ? -bus.bus_a : bus.bus_a;
    mag_b     = sign_b ? -bus.bus_b : bus.bus_b;
    // Remainder takes the dividend's sign; everything else the XOR of both
    neg_start = (is_div && bus.op[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero  = is_div && (bus.bus_b == '0);
    div_ovf   = is_div && !bus.op[0] && (bus.bus_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                (bus.bus_b == '1);
    special   = div_zero || div_ovf;
    if (div_zero) begin
      spec_res = bus.op[1] ? bus.bus_a : '1;
    end else begin
      spec_res = bus.op[1] ? '0 : bus.bus_a;
    end
  end

  // One iteration step of the active algorithm and the result it would finish with
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_shift;
  logic [WIDTH:0]      div_diff;
  logic                div_ge;
  logic [2*WIDTH-1:0]  acc_step;
  logic [2*WIDTH-1:0]  prod_raw;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    div_sel;
  logic [WIDTH-1:0]    calc_res;
  logic [WIDTH-1:0]    fin_res;
  logic                calc_last;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = (div_shift >= {1'b0, opb_q});
    if (op_q[2]) begin
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
`ifdef MULDIV_FAST_MUL_EN
    prod_raw  = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};
    calc_last = !op_q[2] || (cnt_q == CntW'(WIDTH - 1));
`else
    prod_raw  = acc_step;
    calc_last = (cnt_q == CntW'(WIDTH - 1));
`endif
    prod_fix = neg_q ? -prod_raw : prod_raw;
    div_sel  = op_q[1] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
    if (op_q[2]) begin
      calc_res = neg_q ? -div_sel : div_sel;
    end else if (op_q[1:0] == 2'b00) begin
      calc_res = prod_fix[WIDTH-1:0];
    end else begin
      calc_res = prod_fix[2*WIDTH-1:WIDTH];
    end
    fin_res = (state_q == StIdle) ? spec_res : calc_res;
  end

  // Control FSM and datapath registers; all outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      res_zero_q <= 1'b1;
      res_neg_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q   <= bus.op;
            busy_q <= 1'b1;
            if (special) begin
              result_q   <= fin_res;
              res_zero_q <= (fin_res == '0);
              res_neg_q  <= fin_res[WIDTH-1];
              done_q     <= 1'b1;
              state_q    <= StDone;
            end else begin
              opa_q   <= mag_a;
              opb_q   <= mag_b;
              neg_q   <= neg_start;
              acc_q   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
              cnt_q   <= '0;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (calc_last) begin
            result_q   <= fin_res;
            res_zero_q <= (fin_res == '0);
            res_neg_q  <= fin_res[WIDTH-1];
            done_q     <= 1'b1;
            state_q    <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.res_zero = res_zero_q;
  assign bus.res_neg  = res_neg_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: scoreboard queue of expected results, one task per
// scenario. Multiply latency follows MULDIV_FAST_MUL_EN.
module tb_alu_muldiv;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat  = 33;
  localparam int SpecLat = 1;

  logic clk;
  logic rst_n;

  alu_muldiv_if #(.WIDTH(W), .OP_SEL(3)) bus ();

  alu_muldiv #(.WIDTH(W), .OP_SEL(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] sb[$];

  // Independent reference built on 64-bit arithmetic
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa, sb_v, q;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    case (op)
      3'b000: begin p = sa * sb_v; return p[31:0]; end
      3'b001: begin p = sa * sb_v; return p[63:32]; end
      3'b010: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb_v; return q[31:0];
      end
      3'b101: begin if (b == 0) return '1; return a / b; end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        q = sa % sb_v; return q[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    if (!op[2]) return MulLat;
    if (b == 0) return SpecLat;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SpecLat;
    return DivLat;
  endfunction

  // Drive a request at the current negedge and record its expected result
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp);
    bus.start = 1'b1;
    bus.op    = op;
    bus.bus_a = a;
    bus.bus_b = b;
    sb.push_back(exp);
  endtask

  // Wait (bounded) for done; start is released after the first edge unless hold is set
  task automatic wait_done(input int limit, input bit hold, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < limit) begin
      @(negedge clk);
      lat++;
      if (!hold) bus.start = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.bus_a = '0;
    bus.bus_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++;
      $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== '0) begin n_fail++;
      $display("FAIL reset_result: got %h want 0", bus.result); end
    n_cmp++; if (bus.res_zero !== 1'b1) begin n_fail++;
      $display("FAIL reset_res_zero: got %b want 1", bus.res_zero); end
    n_cmp++; if (bus.res_neg !== 1'b0) begin n_fail++;
      $display("FAIL reset_res_neg: got %b want 0", bus.res_neg); end
  endtask

  // Table of known-answer ops: op, a, b, expected
  task automatic test_table(input string name, input logic [2:0] ops[],
                            input logic [W-1:0] as[], input logic [W-1:0] bs[],
                            input logic [W-1:0] exs[], input int lats[]);
    int lat;
    bit seen;
    logic [W-1:0] exp;
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], as[i], bs[i], exs[i]);
      wait_done(60, 1'b0, lat, seen);
      n_cmp++; if (!seen || lat != lats[i]) begin n_fail++;
        $display("FAIL %s_lat[%0d]: got %0d (seen %b) want %0d", name, i, lat, seen, lats[i]);
      end
      exp = sb.pop_front();
      n_cmp++; if (bus.result !== exp) begin n_fail++;
        $display("FAIL %s_result[%0d]: got %h want %h", name, i, bus.result, exp); end
      n_cmp++; if (bus.res_zero !== (exp == '0)) begin n_fail++;
        $display("FAIL %s_res_zero[%0d]: got %b want %b", name, i, bus.res_zero, exp == '0);
      end
      n_cmp++; if (bus.res_neg !== exp[W-1]) begin n_fail++;
        $display("FAIL %s_res_neg[%0d]: got %b want %b", name, i, bus.res_neg, exp[W-1]); end
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++;
        $display("FAIL %s_busy_drop[%0d]: got %b want 0", name, i, bus.busy); end
    end
  endtask

  task automatic test_mul();
    test_table("mul",
      '{3'b000, 3'b001, 3'b010, 3'b011, 3'b011},
      '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0},
      '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{32'hFFFF_FFEB, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0},
      '{MulLat, MulLat, MulLat, MulLat, MulLat});
  endtask

  task automatic test_div();
    test_table("div",
      '{3'b100, 3'b110, 3'b101, 3'b111},
      '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20},
      '{32'd6, 32'd6, 32'd6, 32'd6},
      '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd3, 32'd2},
      '{DivLat, DivLat, DivLat, DivLat});
  endtask

  task automatic test_special();
    test_table("special",
      '{3'b100, 3'b111, 3'b100, 3'b110},
      '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000},
      '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0},
      '{SpecLat, SpecLat, SpecLat, SpecLat});
  endtask

  task automatic test_random();
    int lat;
    bit seen;
    logic [2:0] op;
    logic [W-1:0] a, b, exp;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? W'($urandom_range(1, 300)) : $urandom;
      issue(op, a, b, model(op, a, b));
      wait_done(60, 1'b0, lat, seen);
      n_cmp++; if (!seen || lat != exp_lat(op, a, b)) begin n_fail++;
        $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, exp_lat(op, a, b)); end
      exp = sb.pop_front();
      n_cmp++; if (bus.result !== exp) begin n_fail++;
        $display("FAIL rand_result[%0d] op%0d %h,%h: got %h want %h", i, op, a, b,
                 bus.result, exp); end
      @(negedge clk);
    end
  endtask

  // Starts during CALC and DONE must be ignored; operand changes mid-op have no effect
  task automatic test_handshake();
    int lat = 0;
    int dones = 0;
    logic [W-1:0] exp;
    issue(3'b101, 32'd100, 32'd7, 32'd14);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 10) begin
        bus.start = 1'b1; bus.op = 3'b000; bus.bus_a = 32'd3; bus.bus_b = 32'd3;
      end
      if (dones == 1 && c == lat + 1) begin
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++;
          $display("FAIL hs_busy_drop: got %b want 0", bus.busy); end
      end
      if (bus.done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          lat = c;
          n_cmp++; if (bus.busy !== 1'b1) begin n_fail++;
            $display("FAIL hs_busy_in_done: got %b want 1", bus.busy); end
          bus.start = 1'b1;
        end
      end
    end
    n_cmp++; if (dones != 1 || lat != DivLat) begin n_fail++;
      $display("FAIL hs_done_pulses: got %0d at %0d want 1 at %0d", dones, lat, DivLat); end
    exp = sb.pop_front();
    n_cmp++; if (bus.result !== exp) begin n_fail++;
      $display("FAIL hs_result: got %h want %h", bus.result, exp); end
  endtask

  // start held high: one accepted op per WIDTH+2 cycles
  task automatic test_back_to_back();
    int lat;
    bit seen;
    logic [W-1:0] exp;
    issue(3'b101, 32'd1000, 32'd9, 32'd111);
    for (int k = 0; k < 3; k++) begin
      wait_done(60, 1'b1, lat, seen);
      n_cmp++; if (!seen || lat != ((k == 0) ? DivLat : W + 2)) begin n_fail++;
        $display("FAIL b2b_interval[%0d]: got %0d want %0d", k, lat,
                 (k == 0) ? DivLat : W + 2); end
      exp = sb.pop_front();
      n_cmp++; if (bus.result !== exp) begin n_fail++;
        $display("FAIL b2b_result[%0d]: got %h want %h", k, bus.result, exp); end
      if (k == 0) issue(3'b111, 32'd1000, 32'd9, 32'd1);
      else if (k == 1) issue(3'b101, 32'd77, 32'd7, 32'd11);
      else bus.start = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    logic [W-1:0] exp;
    issue(3'b100, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD);
    repeat (11) begin @(negedge clk); bus.start = 1'b0; end
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_ctrl: got busy %b done %b want 0 0", bus.busy, bus.done); end
    n_cmp++; if (bus.result !== '0 || bus.res_zero !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_result: got %h z%b want 0 z1", bus.result, bus.res_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'b110, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE);
    wait_done(60, 1'b0, lat, seen);
    n_cmp++; if (!seen || lat != DivLat) begin n_fail++;
      $display("FAIL rstmid_lat: got %0d want %0d", lat, DivLat); end
    exp = sb.pop_front();
    n_cmp++; if (bus.result !== exp) begin n_fail++;
      $display("FAIL rstmid_after: got %h want %h", bus.result, exp); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    n_cmp++; if (sb.size() != 0) begin n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
